// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core IO bus: DATA pushes into a TX FIFO,
// STATUS exposes level/overflow/full/busy; the line is shifted from a registered output.
module io_uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;
  logic            pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, level;
  logic            full, empty, overflow;

  logic            io_sel;
  logic [1:0]      sel;
  logic            push_req, push, drop, clr_ovf;
  logic            unused_bits;

  assign io_sel      = io_addr[22];
  assign sel         = io_addr[3:2];
  assign unused_bits = ^{io_addr[31:23], io_addr[21:4], io_addr[1:0], io_wdata[31:8]};

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A push into a full FIFO still lands when the FSM frees a slot on the same edge.
  assign push_req = io_wr && io_sel && (sel == 2'd0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign clr_ovf  = io_wr && io_sel && (sel == 2'd1) && io_wdata[2];

  assign tx_busy = (state != IDLE) || !empty;

  function automatic logic [31:0] pack_status(input logic [PW-1:0] lvl, input logic ovf,
                                              input logic f, input logic busy);
    pack_status          = '0;
    pack_status[3 +: PW] = lvl;
    pack_status[2]       = ovf;
    pack_status[1]       = f;
    pack_status[0]       = busy;
  endfunction

  always_comb begin
    io_rdata = '0;
    if (io_sel && (sel == 2'd1))
      io_rdata = pack_status(level, overflow, full, tx_busy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_wdata[7:0];
    shift <= shift_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = uart_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr[AW-1:0]];
          cnt_n   = CNT_LAST;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = CNT_LAST;
          idx_n   = 3'd0;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = CNT_LAST;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[idx_n];
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr[AW-1:0]];
            cnt_n   = CNT_LAST;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      uart_tx <= tx_n;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at DIV=4, depth 8: a line monitor decodes 8N1 frames
// and records their start edges; bus writes/reads are checked against hand-derived values.
module tb_io_uart_tx;

  localparam logic [31:0] A_DATA = 32'h0040_0000;
  localparam logic [31:0] A_STAT = 32'h0040_0004;
  localparam logic [31:0] A_RSVD = 32'h0040_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_wr;
  logic        uart_tx, tx_busy;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  logic       smp [40];
  int         k = 0;
  bit         rx_on = 1'b0;
  logic [7:0] rx_q [$];
  int         start_q [$];

  io_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(250), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr),
    .io_rdata(io_rdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (uart_tx === 1'b0) begin
        rx_on = 1'b1;
        smp[0] = 1'b0;
        k = 1;
        start_q.push_back(edge_cnt);
      end
    end else begin
      smp[k] = uart_tx;
      k++;
      if (k == 40) begin
        logic       stable;
        logic [7:0] b;
        rx_on  = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++)
          for (int j = 1; j < 4; j++)
            if (smp[4*i+j] !== smp[4*i]) stable = 1'b0;
        chk("bit_stable", {31'd0, stable}, 32'd1);
        chk("start_bit", {28'd0, smp[0], smp[1], smp[2], smp[3]}, 32'h0);
        chk("stop_bit", {28'd0, smp[36], smp[37], smp[38], smp[39]}, 32'hF);
        for (int i = 0; i < 8; i++) b[i] = smp[4 + 4*i];
        rx_q.push_back(b);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int n);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    n = edge_cnt;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  initial begin
    int n, n0, base, q0;
    logic [31:0] s;
    reset = 1'b1; io_addr = '0; io_wdata = '0; io_wr = 1'b0;
    #1;
    chk("por_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("por_busy", {31'd0, tx_busy}, 32'd0);
    rd(A_STAT, s); chk("por_status", s, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset mid start bit: line must return high without a clock edge.
    wr(A_DATA, 32'h0F, n);
    wait_edge(n + 2);
    chk("t1_start_low", {31'd0, uart_tx}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t1_uart_tx", {31'd0, uart_tx}, 32'd1);
    rd(A_STAT, s); chk("t1_status", s, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("t1_no_frame", rx_q.size(), 32'd0);

    // Single byte 0x55 with exact timing.
    wr(A_DATA, 32'h55, n);
    chk("t2_idle_before", {31'd0, uart_tx}, 32'd1);
    wait_edge(n + 40);
    chk("t2_busy_end", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    chk("t2_busy_low", {31'd0, tx_busy}, 32'd0);
    chk("t2_frames", rx_q.size(), 32'd1);
    if (rx_q.size() >= 1) begin
      chk("t2_byte", {24'd0, rx_q[0]}, 32'h55);
      chk("t2_start_edge", start_q[start_q.size()-1], n + 1);
    end
    rd(A_STAT, s); chk("t2_status", s, 32'h0);

    // Burst of 10 on consecutive edges: 9 accepted, 10th overflows.
    base = rx_q.size();
    q0 = start_q.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      io_addr = A_DATA; io_wdata = i; io_wr = 1'b1;
    end
    @(negedge clk);
    io_wr = 1'b0; io_wdata = '0;
    n0 = edge_cnt - 9;
    rd(A_STAT, s); chk("t3_status_full", s, 32'h47);

    // Clear overflow, then refill once a slot frees.
    wr(A_STAT, 32'h4, n);
    rd(A_STAT, s); chk("t4_ovf_clear", s, 32'h43);
    for (int i = 0; i < 100 && s[1]; i++) begin
      @(negedge clk);
      rd(A_STAT, s);
    end
    chk("t4_not_full", s, 32'h39);
    wr(A_DATA, 32'hAA, n);
    rd(A_STAT, s); chk("t4_refill", s, 32'h43);
    for (int i = 0; i < 600 && rx_q.size() < base + 10; i++) @(negedge clk);
    chk("t3_frames", rx_q.size(), base + 10);
    if (rx_q.size() >= base + 10) begin
      for (int i = 0; i < 9; i++) chk("t3_byte", {24'd0, rx_q[base+i]}, i);
      chk("t4_byte", {24'd0, rx_q[base+9]}, 32'hAA);
      chk("t3_first_start", start_q[q0], n0 + 1);
      for (int i = 1; i < 10; i++) chk("t3_gap", start_q[q0+i] - start_q[q0+i-1], 32'd40);
    end
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    chk("t4_busy_done", {31'd0, tx_busy}, 32'd0);

    // Off-page and reserved accesses have no effect.
    base = rx_q.size();
    wr(32'h0000_0000, 32'hA5, n);
    rd(A_STAT, s); chk("t5_level", s, 32'h0);
    rd(32'h0000_0000, s); chk("t5_rdata_off", s, 32'h0);
    wr(A_RSVD, 32'hFF, n);
    rd(A_RSVD, s); chk("t5_rsvd_rd", s, 32'h0);
    rd(A_DATA, s); chk("t5_data_rd", s, 32'h0);
    repeat (60) @(negedge clk);
    chk("t5_no_frame", rx_q.size(), base);
    chk("t5_line_idle", {31'd0, uart_tx}, 32'd1);

    // Reset during data bit 3 with three bytes queued.
    wr(A_DATA, 32'hF0, n);
    wr(A_DATA, 32'h11, n0);
    wr(A_DATA, 32'h22, n0);
    wr(A_DATA, 32'h33, n0);
    rd(A_STAT, s); chk("t6_queued", s, 32'h19);
    rd(32'h0000_0004, s); chk("t6_off_page_stat", s, 32'h0);
    io_addr = '0;
    wait_edge(n + 18);
    chk("t6_bit3_low", {31'd0, uart_tx}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t6_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("t6_busy", {31'd0, tx_busy}, 32'd0);
    rd(A_STAT, s); chk("t6_status", s, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_frame", rx_q.size(), base);
    chk("t6_line_idle", {31'd0, uart_tx}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
